// File: rtl/adc_scan_seq.sv
// Multi-channel sampling ADC behavioural model with scan sequencer.
// Scans the enabled channels in ascending order, holds each sample for a fixed
// conversion time, averages 2^OSR_LOG2 samples and presents one result per
// channel on a valid/ready port with a sticky overrun flag.
module adc_scan_seq #(
  parameter real         V_MAX       = 3.3,
  parameter int unsigned BITS        = 12,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CONV_CYCLES = 4,
  parameter int unsigned OSR_LOG2    = 0,
  parameter int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  real             analog_in [N_CH],
  input  logic [N_CH-1:0] ch_mask,
  input  logic            start,
  input  logic            cont_en,
  output logic [BITS-1:0] out_data,
  output logic [CH_W-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            overrun,
  input  logic            ovr_clr
);

  localparam int unsigned CNT_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int unsigned SCNT_W = OSR_LOG2 + 1;
  localparam int unsigned N_SAMP = 1 << OSR_LOG2;
  localparam int unsigned ACC_W  = BITS + OSR_LOG2;
  localparam logic [BITS-1:0] MAX_CODE   = '1;
  localparam real             MAX_CODE_R = real'((64'd1 << BITS) - 64'd1);

  typedef enum logic [1:0] {StIdle, StSample, StConv, StResult} state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   scan_mask_q, scan_mask_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;
  logic [SCNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BITS-1:0]   sample_q, sample_d;
  logic [BITS-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              drop;
  logic [CH_W:0]     nxt;

  // Truncating quantiser with clamping at both rails.
  function automatic logic [BITS-1:0] quantise(input real v);
    if (v >= V_MAX) begin
      return MAX_CODE;
    end else if (v <= 0.0) begin
      return '0;
    end else begin
      return BITS'($rtoi(v * MAX_CODE_R / V_MAX));
    end
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [CH_W-1:0] lowest_bit(input logic [N_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [CH_W:0] next_bit(input logic [N_CH-1:0] m,
                                             input logic [CH_W-1:0] cur);
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) begin
        found = 1'b1;
        idx   = CH_W'(i);
      end
    end
    return {found, idx};
  endfunction

  // State and datapath registers; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scan_mask_q <= '0;
      cur_ch_q    <= '0;
      conv_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_mask_q <= scan_mask_d;
      cur_ch_q    <= cur_ch_d;
      conv_cnt_q  <= conv_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Scan sequencer next-state, accumulation and result handshake.
  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    cur_ch_d    = cur_ch_q;
    conv_cnt_d  = conv_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    acc_d       = acc_q;
    sample_d    = sample_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    drop        = 1'b0;
    nxt         = '0;

    // An accepted result retires unless a new one loads in the same cycle.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((start || cont_en) && (ch_mask != '0)) begin
          scan_mask_d = ch_mask;
          cur_ch_d    = lowest_bit(ch_mask);
          state_d     = StSample;
        end
      end
      StSample: begin
        sample_d   = quantise(analog_in[cur_ch_q]);
        conv_cnt_d = '0;
        state_d    = StConv;
      end
      StConv: begin
        conv_cnt_d = conv_cnt_q + CNT_W'(1);
        if (conv_cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
          acc_d      = acc_q + ACC_W'(sample_q);
          samp_cnt_d = samp_cnt_q + SCNT_W'(1);
          if ((samp_cnt_q + SCNT_W'(1)) < SCNT_W'(N_SAMP)) begin
            state_d = StSample;
          end else begin
            state_d = StResult;
          end
        end
      end
      StResult: begin
        if (out_valid_q && !out_ready) begin
          drop = 1'b1;
        end else begin
          out_data_d  = BITS'(acc_q >> OSR_LOG2);
          out_ch_d    = cur_ch_q;
          out_valid_d = 1'b1;
        end
        acc_d      = '0;
        samp_cnt_d = '0;
        nxt        = next_bit(scan_mask_q, cur_ch_q);
        if (nxt[CH_W]) begin
          cur_ch_d = nxt[CH_W-1:0];
          state_d  = StSample;
        end else if (cont_en) begin
          scan_mask_d = ch_mask;
          cur_ch_d    = lowest_bit(ch_mask);
          state_d     = (ch_mask != '0) ? StSample : StIdle;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Set has priority over clear.
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (drop) overrun_d = 1'b1;
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed self-checking bench for adc_scan_seq: default instance plus a
// second instance with 4x oversampling.
module tb_adc_scan_seq;

  logic        clk;
  logic        rst_n;
  real         analog [4];
  logic [3:0]  mask;
  logic        start, cont_en, out_ready, ovr_clr;
  logic [11:0] o_data;
  logic [1:0]  o_ch;
  logic        o_valid, o_busy, o_ovr;

  logic        start_b;
  logic [11:0] o2_data;
  logic [1:0]  o2_ch;
  logic        o2_valid, o2_busy, o2_ovr;

  int n_checks = 0;
  int n_err    = 0;

  int          n_res;
  logic [1:0]  res_ch   [4];
  logic [11:0] res_data [4];

  adc_scan_seq u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .analog_in (analog),
    .ch_mask   (mask),
    .start     (start),
    .cont_en   (cont_en),
    .out_data  (o_data),
    .out_ch    (o_ch),
    .out_valid (o_valid),
    .out_ready (out_ready),
    .busy      (o_busy),
    .overrun   (o_ovr),
    .ovr_clr   (ovr_clr)
  );

  adc_scan_seq #(.OSR_LOG2(2)) u_osr (
    .clk       (clk),
    .rst_n     (rst_n),
    .analog_in (analog),
    .ch_mask   (4'b0001),
    .start     (start_b),
    .cont_en   (1'b0),
    .out_data  (o2_data),
    .out_ch    (o2_ch),
    .out_valid (o2_valid),
    .out_ready (1'b1),
    .busy      (o2_busy),
    .overrun   (o2_ovr),
    .ovr_clr   (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Record every valid cycle (out_ready assumed high) over a window.
  task automatic collect(input int cycles);
    n_res = 0;
    for (int i = 0; i < cycles; i++) begin
      if (o_valid && n_res < 4) begin
        res_ch[n_res]   = o_ch;
        res_data[n_res] = o_data;
        n_res++;
      end
      tick();
    end
  endtask

  // Single-shot scan of channel 0 with exact latency check.
  task automatic single(input real v, input logic [31:0] exp, input string tag);
    analog[0] = v;
    mask      = 4'b0001;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk({tag, "_valid_early"}, o_valid, 0);
    tick();
    chk({tag, "_valid"}, o_valid, 1);
    chk({tag, "_data"}, o_data, exp);
    chk({tag, "_ch"}, o_ch, 0);
    tick();
    chk({tag, "_valid_clr"}, o_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int   cnt;
    logic ovr_seen;
    logic [11:0] last;

    rst_n = 1'b0;
    mask = '0; start = 0; cont_en = 0; out_ready = 1; ovr_clr = 0; start_b = 0;
    for (int i = 0; i < 4; i++) analog[i] = 0.0;
    repeat (2) tick();
    chk("rst_data", o_data, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ovr", o_ovr, 0);
    rst_n = 1'b1;
    tick();

    // Quantisation
    single(1.65, 2047, "q_mid");
    single(3.5, 4095, "q_over");
    single(-0.2, 0, "q_neg");
    single(1.0, 1240, "q_1v0");

    // Scan order over mask 1010
    analog[1] = 0.5; analog[3] = 3.0; mask = 4'b1010;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(20);
    chk("scan_nres", n_res, 2);
    chk("scan_ch0", res_ch[0], 1);
    chk("scan_d0", res_data[0], 620);
    chk("scan_ch1", res_ch[1], 3);
    chk("scan_d1", res_data[1], 3722);
    chk("scan_busy", o_busy, 0);

    // Start with empty mask is ignored
    mask = 4'b0000; start = 1'b1;
    tick();
    chk("mask0_busy_a", o_busy, 0);
    tick();
    chk("mask0_busy_b", o_busy, 0);
    start = 1'b0;

    // Backpressure and overrun
    analog[0] = 1.65; mask = 4'b0001; out_ready = 1'b0; cont_en = 1'b1;
    tick();
    tick();
    analog[0] = 1.0;
    repeat (5) tick();
    chk("bp_valid1", o_valid, 1);
    chk("bp_data1", o_data, 2047);
    chk("bp_ovr_before", o_ovr, 0);
    repeat (6) tick();
    chk("bp_ovr_set", o_ovr, 1);
    chk("bp_valid_held", o_valid, 1);
    chk("bp_data_held", o_data, 2047);
    out_ready = 1'b1; ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    chk("bp_ovr_clr", o_ovr, 0);
    chk("bp_valid_acc", o_valid, 0);
    cnt = 0; ovr_seen = 1'b0; last = '0;
    for (int i = 0; i < 15; i++) begin
      if (o_valid) begin
        cnt++;
        last = o_data;
      end
      if (o_ovr) ovr_seen = 1'b1;
      tick();
    end
    chk("stream_cnt", cnt, 2);
    chk("stream_ovr", ovr_seen, 0);
    chk("stream_data", last, 1240);
    cont_en = 1'b0;
    for (int i = 0; i < 20 && o_busy; i++) tick();
    chk("cont_stop_busy", o_busy, 0);
    tick();

    // Asynchronous reset mid-conversion
    out_ready = 1'b0; analog[0] = 3.0; mask = 4'b0001; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_data", o_data, 3722);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("pre_rst_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_data", o_data, 0);
    chk("arst_ch", o_ch, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_ovr", o_ovr, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    single(0.5, 620, "post_rst");

    // Oversampling: 1.0, 1.0, 2.0, 2.0 averaged
    analog[0] = 1.0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (10) tick();
    analog[0] = 2.0;
    repeat (10) tick();
    chk("osr_valid_early", o2_valid, 0);
    tick();
    chk("osr_valid", o2_valid, 1);
    chk("osr_data", o2_data, 1860);
    chk("osr_ch", o2_ch, 0);

    // Mask change mid-scan is ignored until next scan
    analog[0] = 1.0; analog[1] = 2.0; analog[2] = 3.0; mask = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mask = 4'b0100;
    collect(18);
    chk("mchg_nres", n_res, 2);
    chk("mchg_ch0", res_ch[0], 0);
    chk("mchg_d0", res_data[0], 1240);
    chk("mchg_ch1", res_ch[1], 1);
    chk("mchg_d1", res_data[1], 2481);
    chk("mchg_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_seq.md
Name: adc_scan_seq

Overview:
- Multi-channel sampling ADC behavioural model with scan sequencer.
- Generalises the single-channel combinational ADC by adding:
  - N_CH real inputs with an enable mask
  - single-shot or continuous scan
  - sample-and-hold with fixed conversion latency
  - 2^OSR_LOG2 oversampling average
  - valid/ready result port with a sticky overrun flag
- Sits between the analog sensor models (current, position) and the digital control logic.

Parameters:
- V_MAX, 3.3, full-scale input voltage (real).
- BITS, 12, result width; max code = 2^BITS-1.
- N_CH, 4, number of analog channels (>=1).
- CONV_CYCLES, 4, clocks per conversion after sampling (>=1).
- OSR_LOG2, 0, log2 of samples averaged per result (0..4).
- CH_W, $clog2(N_CH) (minimum 1), channel-index width (derived).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- analog_in  in  real[N_CH]  analog channel voltages.
- ch_mask  in  N_CH  channel enable; bit i enables channel i.
- start  in  1  single-scan request; sampled in IDLE only.
- cont_en  in  1  continuous scan while high.
- out_data  out  BITS  averaged result code.
- out_ch  out  CH_W  channel index of out_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky: a result was dropped.
- ovr_clr  in  1  clears overrun.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all counters, accumulator and latched mask = 0.
  - out_data = 0, out_ch = 0, out_valid = 0, busy = 0, overrun = 0.
  - Reset mid-scan aborts the scan; the partial accumulation is discarded.
- Quantisation, at each SAMPLE cycle, of analog_in[cur_ch]:
  - analog_in >= V_MAX -> 2^BITS-1.
  - analog_in <= 0.0 -> 0.
  - otherwise $rtoi(analog_in*(2^BITS-1)/V_MAX), i.e. truncation.
- State machine:
  - IDLE: if (start | cont_en) and ch_mask != 0, latch ch_mask as scan_mask, set cur_ch = lowest set bit, go to SAMPLE. If ch_mask == 0, the request is ignored and the state stays IDLE.
  - SAMPLE (1 cycle): the quantised code is held in the sample register; conversion counter = 0; go to CONV.
  - CONV: counter increments each cycle. When counter == CONV_CYCLES-1:
    - accumulator += held code; sample count increments.
    - If sample count < 2^OSR_LOG2, go to SAMPLE; otherwise go to RESULT.
  - RESULT (1 cycle):
    - Result = accumulator >> OSR_LOG2 (truncated); accumulator width is BITS+OSR_LOG2, no overflow possible.
    - If out_valid is high and out_ready is low this cycle, the new result is dropped and overrun is set. Otherwise out_data, out_ch and out_valid = 1 are registered.
    - Accumulator and sample count clear.
    - Next channel = next higher set bit of scan_mask.
    - If none remains: if cont_en is high, relatch ch_mask and go to SAMPLE on the lowest set bit (IDLE if the new mask is 0); otherwise go to IDLE.
- Latency:
  - Start seen in IDLE at cycle k -> SAMPLE at k+1 -> RESULT at k+2+CONV_CYCLES*2^OSR_LOG2 + (2^OSR_LOG2-1).
  - out_valid is high from the following cycle.
- Handshake:
  - out_valid clears on the cycle after out_valid & out_ready.
  - out_data and out_ch are stable while out_valid & !out_ready.
  - Accept and new result in the same RESULT cycle: the new result loads and out_valid stays 1, with no overrun.
- Mask changes mid-scan have no effect until the next scan starts (scan_mask is latched).
- start while busy is ignored.
- cont_en falling mid-scan: the current scan completes, then the block goes to IDLE.
- overrun: cleared by ovr_clr. If set and clear occur in the same cycle, set wins.

Test Plan:
- Quantisation, defaults, mask = 0001, single scan:
  - analog_in[0] = 1.65 -> out_data = 2047, out_ch = 0.
  - 3.5 -> 4095; -0.2 -> 0; 1.0 -> 1240.
  - out_valid rises exactly 7 cycles after start with CONV_CYCLES = 4.
- Scan order: mask = 1010, inputs ch1 = 0.5, ch3 = 3.0 -> two results in order: (ch 1, 620), then (ch 3, 3722); busy drops after the second; no ch0/ch2 results.
- Oversampling, OSR_LOG2 = 2: ch0 ramps 1.0, 1.0, 2.0, 2.0 across successive samples -> out_data = (1240+1240+2481+2481)>>2 = 1860.
- Backpressure: cont_en = 1, mask = 0001, out_ready = 0 -> first result held unchanged, second result dropped and overrun = 1. ovr_clr pulse clears it; with out_ready = 1, results stream and overrun stays 0.
- Corner controls:
  - start with mask = 0 -> busy stays 0.
  - rst_n low mid-CONV -> all outputs 0 immediately (asynchronous).
  - After release, a fresh start produces a correct result with no stale accumulation.
- Mask change mid-scan: mask 0011 is latched, and changing it to 0100 during ch0 conversion still yields ch0 then ch1 results.
